// File: rtl/fb_pkg.sv
// Shared types and helpers for the N-buffered frame buffer.
package fb_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef logic [1:0] buf_idx_t;

  localparam buf_idx_t NO_BUF = 2'd3;

  // MSB replication so full-scale 565 maps to full-scale 888.
  function automatic logic [23:0] rgb565_to_888(input rgb565_t p);
    return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
  endfunction

endpackage

// File: rtl/fb_role_tracker.sv
// Display/write/pending role bookkeeping; roles only move on frame events.
module fb_role_tracker
  import fb_pkg::*;
#(
  parameter int NUM_BUFFERS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmp_in,
  input  logic        eof_in,
  output buf_idx_t    d_out,
  output buf_idx_t    w_out,
  output logic        wr_ready_out,
  output logic        swapped_out,
  output logic [15:0] dropped_out
);

  buf_idx_t    d_q, d_d, w_q, w_d, p_q, p_d;
  logic        flag_q, flag_d;
  logic        ready_q, ready_d;
  logic        swapped_q, swapped_d;
  logic [15:0] dropped_q, dropped_d;
  logic        p_valid, drop;
  buf_idx_t    third;

  assign p_valid = (p_q != NO_BUF);
  assign third   = buf_idx_t'(2'd3 - d_q - w_q);

  always_comb begin
    d_d       = d_q;
    w_d       = w_q;
    p_d       = p_q;
    flag_d    = flag_q;
    swapped_d = 1'b0;
    drop      = 1'b0;
    ready_d   = 1'b1;
    if (NUM_BUFFERS == 3) begin
      if (cmp_in && eof_in) begin
        d_d       = w_q;
        w_d       = d_q;
        p_d       = NO_BUF;
        drop      = p_valid;
        swapped_d = 1'b1;
      end else if (cmp_in) begin
        // An undisplayed pending frame is recycled as the next write target.
        p_d  = w_q;
        w_d  = p_valid ? p_q : third;
        drop = p_valid;
      end else if (eof_in && p_valid) begin
        d_d       = p_q;
        p_d       = NO_BUF;
        swapped_d = 1'b1;
      end
    end else begin
      if (eof_in && (cmp_in || flag_q)) begin
        d_d       = w_q;
        w_d       = d_q;
        flag_d    = 1'b0;
        swapped_d = 1'b1;
      end else if (cmp_in) begin
        flag_d = 1'b1;
      end
      ready_d = ~flag_d;
    end
    dropped_d = (drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= 2'd0;
      w_q       <= 2'd1;
      p_q       <= NO_BUF;
      flag_q    <= 1'b0;
      ready_q   <= 1'b0;
      swapped_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      d_q       <= d_d;
      w_q       <= w_d;
      p_q       <= p_d;
      flag_q    <= flag_d;
      ready_q   <= ready_d;
      swapped_q <= swapped_d;
      dropped_q <= dropped_d;
    end
  end

  assign d_out        = d_q;
  assign w_out        = w_q;
  assign wr_ready_out = ready_q;
  assign swapped_out  = swapped_q;
  assign dropped_out  = dropped_q;

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM; optional output register gives 2-cycle latency.
module xilinx_single_port_ram_read_first #(
  parameter int RAM_WIDTH   = 16,
  parameter int RAM_DEPTH   = 1024,
  parameter int RAM_LATENCY = 2,
  localparam int AW         = $clog2(RAM_DEPTH)
) (
  input  logic [AW-1:0]        addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 clka,
  input  logic                 wea,
  input  logic                 ena,
  input  logic                 rsta,
  input  logic                 regcea,
  output logic [RAM_WIDTH-1:0] douta
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_q;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data_q <= mem[addra];
    end
  end

  if (RAM_LATENCY == 1) begin : g_low_lat
    assign douta = ram_data_q;
  end else begin : g_high_perf
    logic [RAM_WIDTH-1:0] douta_q;
    always_ff @(posedge clka) begin
      if (rsta)        douta_q <= '0;
      else if (regcea) douta_q <= ram_data_q;
    end
    assign douta = douta_q;
  end

endmodule

// File: rtl/frame_buffer_nbuf.sv
// N-buffered (2/3) frame buffer: RGB565 low-res write stream in, upscaled RGB888 scan-out.
module frame_buffer_nbuf
  import fb_pkg::*;
#(
  parameter int NUM_BUFFERS        = 3,
  parameter int SCALE_SHIFT        = 2,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720,
  parameter int READ_LATENCY       = 2,
  localparam int SCREEN_WIDTH      = FULL_SCREEN_WIDTH >> SCALE_SHIFT,
  localparam int SCREEN_HEIGHT     = FULL_SCREEN_HEIGHT >> SCALE_SHIFT,
  localparam int DEPTH             = SCREEN_WIDTH * SCREEN_HEIGHT,
  localparam int ADDR_W            = $clog2(DEPTH)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              video_last_pixel_in,
  input  logic              wr_valid_in,
  output logic              wr_ready_out,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [15:0]       wr_pixel_in,
  input  logic              wr_last_in,
  output logic [23:0]       rgb_out,
  output logic              swapped_out,
  output logic [15:0]       dropped_frames_out,
  output logic              addr_err_out
);

  if (NUM_BUFFERS != 2 && NUM_BUFFERS != 3) begin : g_bad_nbuf
    $error("frame_buffer_nbuf: NUM_BUFFERS must be 2 or 3");
  end

  buf_idx_t d_idx, w_idx;
  logic     accept, cmp, in_range, good;
  logic     addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [NUM_BUFFERS-1:0][15:0] bank_dout;

  assign accept   = wr_valid_in && wr_ready_out;
  assign cmp      = accept && wr_last_in;
  assign in_range = {1'b0, wr_addr_in} < (ADDR_W+1)'(DEPTH);
  assign rd_addr  = ADDR_W'(32'(hcount_in >> SCALE_SHIFT) +
                            32'(SCREEN_WIDTH) * 32'(vcount_in >> SCALE_SHIFT));
  assign good     = (hcount_in < 11'(FULL_SCREEN_WIDTH)) &&
                    (vcount_in < 10'(FULL_SCREEN_HEIGHT));

  fb_role_tracker #(.NUM_BUFFERS(NUM_BUFFERS)) u_roles (
    .clk          (pixel_clk_in),
    .rst_n        (rst_n_in),
    .cmp_in       (cmp),
    .eof_in       (video_last_pixel_in),
    .d_out        (d_idx),
    .w_out        (w_idx),
    .wr_ready_out (wr_ready_out),
    .swapped_out  (swapped_out),
    .dropped_out  (dropped_frames_out)
  );

  // The write bank owns its port; every other bank serves the scan-out address.
  for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_bank
    logic              is_w;
    logic [ADDR_W-1:0] bank_addr;
    assign is_w      = (w_idx == buf_idx_t'(i));
    assign bank_addr = is_w ? wr_addr_in : rd_addr;
    xilinx_single_port_ram_read_first #(
      .RAM_WIDTH   (16),
      .RAM_DEPTH   (DEPTH),
      .RAM_LATENCY (READ_LATENCY)
    ) u_ram (
      .addra  (bank_addr),
      .dina   (wr_pixel_in),
      .clka   (pixel_clk_in),
      .wea    (accept && is_w && in_range),
      .ena    (1'b1),
      .rsta   (~rst_n_in),
      .regcea (1'b1),
      .douta  (bank_dout[i])
    );
  end

  assign addr_err_d = addr_err_q | (accept && !in_range);

  // Display index travels with the pixel so a swap never mixes banks mid-pixel.
  logic [READ_LATENCY:1] vld_pipe_q, vld_pipe_d;
  buf_idx_t              d_pipe_q [1:READ_LATENCY];
  buf_idx_t              d_pipe_d [1:READ_LATENCY];

  always_comb begin
    vld_pipe_d[1] = good;
    d_pipe_d[1]   = d_idx;
    for (int k = 2; k <= READ_LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      d_pipe_d[k]   = d_pipe_q[k-1];
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe_q <= '0;
      for (int k = 1; k <= READ_LATENCY; k++) d_pipe_q[k] <= '0;
      addr_err_q <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      for (int k = 1; k <= READ_LATENCY; k++) d_pipe_q[k] <= d_pipe_d[k];
      addr_err_q <= addr_err_d;
    end
  end

  logic [15:0] sel_pix;
  always_comb begin
    sel_pix = '0;
    for (int i = 0; i < NUM_BUFFERS; i++)
      if (d_pipe_q[READ_LATENCY] == buf_idx_t'(i)) sel_pix = bank_dout[i];
    rgb_out = vld_pipe_q[READ_LATENCY] ? rgb565_to_888(sel_pix) : 24'h0;
  end

  assign addr_err_out = addr_err_q;

endmodule

// File: doc/frame_buffer_nbuf.md
Name: frame_buffer_nbuf

Overview:
Parametrised N-buffered (2 or 3) frame buffer between the ray-render write stream and the video_sig_gen scan-out.
- The write side is a valid/ready stream of RGB565 pixels at low-res addresses; the read side upscales by 2^SCALE_SHIFT and outputs RGB888.
- Frame roles (display/write/pending) swap only at frame boundaries.
- With 3 buffers the renderer never stalls: stale completed frames are dropped and counted.

Parameters:
NUM_BUFFERS, 3, buffer count; legal values 2 or 3 only.
SCALE_SHIFT, 2, log2 of the upscale factor in each axis.
FULL_SCREEN_WIDTH, 1280, active display width.
FULL_SCREEN_HEIGHT, 720, active display height.
READ_LATENCY, 2, BRAM read latency (HIGH_PERFORMANCE mode).
Derived localparams: SCREEN_WIDTH = FULL_SCREEN_WIDTH>>SCALE_SHIFT; SCREEN_HEIGHT likewise; DEPTH = SCREEN_WIDTH*SCREEN_HEIGHT; ADDR_W = $clog2(DEPTH).

Ports:
pixel_clk_in  in  1  sole clock.
rst_n_in  in  1  asynchronous, active-low reset.
hcount_in  in  11  scan-out column from video_sig_gen.
vcount_in  in  10  scan-out row.
video_last_pixel_in  in  1  one-cycle pulse on the last active pixel of a displayed frame.
wr_valid_in  in  1  write pixel valid.
wr_ready_out  out  1  write pixel accepted when valid&&ready.
wr_addr_in  in  ADDR_W  low-res pixel address, arbitrary order.
wr_pixel_in  in  16  RGB565 pixel.
wr_last_in  in  1  qualifies the final pixel of a render frame.
rgb_out  out  24  RGB888 pixel, READ_LATENCY cycles after hcount/vcount.
swapped_out  out  1  one-cycle pulse when the display buffer changes.
dropped_frames_out  out  16  saturating count of completed frames never displayed.
addr_err_out  out  1  sticky; set on an accepted write with wr_addr_in >= DEPTH.

Behaviour:
- Reset (async assert, sync release): display idx D=0, write idx W=1, pending idx P invalid. Outputs: rgb_out=0, swapped_out=0, dropped_frames_out=0, addr_err_out=0, wr_ready_out=0. wr_ready_out goes to 1 the first cycle after release. A partially written frame is discarded.
- Write accept: each accepted pixel writes buffer W at wr_addr_in. An out-of-range address is accepted but not written, and sets addr_err_out. Buffers D and P are never written.
- Read: addr = (hcount_in>>SCALE_SHIFT) + SCREEN_WIDTH*(vcount_in>>SCALE_SHIFT), applied combinationally to buffer D. Each stage of the READ_LATENCY-deep pipeline carries D and good = (hcount_in<FULL_SCREEN_WIDTH && vcount_in<FULL_SCREEN_HEIGHT). The output mux uses the delayed D, so a swap never mixes banks within a pixel.
- Output: rgb_out = good ? {r,r[4:2], g,g[5:4], b,b[4:2]} : 0. This is bit replication, so 5'h1F maps to 8'hFF.
- Events: CMP = accepted wr_last_in; EOF = video_last_pixel_in.
- NUM_BUFFERS=3 roles:
  - CMP only, P invalid: P<=W; W<=the third index; P valid.
  - CMP only, P valid: old P is overwritten. P<=W; W<=old P; dropped++.
  - EOF only, P valid: D<=P; the old D becomes the third index; P invalid; swapped pulse.
  - EOF only, P invalid: no change.
  - CMP and EOF in the same cycle: D<=W; W<=old D; if P was valid, dropped++ and P invalid; swapped pulse.
  - wr_ready_out stays 1.
- NUM_BUFFERS=2 roles:
  - CMP: wr_ready_out<=0; completed flag set.
  - EOF with flag set: swap D and W; flag cleared; wr_ready_out<=1; swapped pulse.
  - CMP and EOF in the same cycle: swap immediately; wr_ready_out stays 1.
  - EOF without flag: no change.
- Role updates take effect the next clock. All swaps occur only on EOF, so the display never tears.
- dropped_frames_out saturates at 16'hFFFF.

Decomposition:
- Package fb_pkg:
  - rgb565_t packed struct;
  - function rgb565_to_888 (replication);
  - typedef buf_idx_t logic [1:0];
  - constant NO_BUF.
- Sub-module fb_role_tracker holds the D/W/P/flag state machine, wr_ready_out, swapped_out and the dropped counter. It is parametrised by NUM_BUFFERS.
- Top level:
  - generate-instantiates NUM_BUFFERS xilinx_single_port_ram_read_first banks;
  - wea = accept && W==i && in-range;
  - address mux per bank, with write address when i==W, else the read address;
  - read pipeline and output mux.

Test Plan:
- Reset release, NUM_BUFFERS=3: fill W with 16'hF800, CMP, then EOF -> swapped_out pulses once; next frame at hcount=0,vcount=0 gives rgb_out=24'hFF0000 after 2 cycles.
- 3-buf overrun: three CMPs (0x001F, 0x07E0, 0xFFFF) before one EOF -> dropped_frames_out=2; the display shows 24'hFFFFFF; wr_ready_out never drops.
- 2-buf stall: CMP mid-frame -> wr_ready_out=0 until EOF, then 1 the next cycle; a write with valid held through the stall lands in the new W.
- Simultaneous CMP+EOF, NUM_BUFFERS=2 and 3 -> D becomes the just-completed buffer; single swapped pulse; wr_ready_out=1.
- Scaling/blanking, SCALE_SHIFT=2: addr 321 = 16'h0841 -> hcount 4..7, vcount 4..7 all yield 24'h080808; hcount=1280 -> rgb_out=0; wr_addr_in=57600 -> addr_err_out=1, memory unchanged.
- Async reset asserted mid-write with P valid -> outputs zero immediately; after release D=0, P invalid, counters 0.
